gb_quad_decoder: RTL and testbench



---
 rtl/gb_quad_decoder_if.sv | 23 ++
 rtl/gb_quad_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_gb_quad_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_quad_decoder_if.sv
// Encoder pin / decoder result bundle for gb_quad_decoder.
// master drives the encoder side, slave is the decoder.
interface gb_quad_decoder_if;
  logic        enc_a;
  logic        enc_b;
  logic        enc_z;
  logic        z_en;
  logic        err_clr;
  logic [31:0] rot_pos;
  logic        dir;
  logic        sync_trg;
  logic [15:0] err_cnt;

  modport master (
    output enc_a, enc_b, enc_z, z_en, err_clr,
    input  rot_pos, dir, sync_trg, err_cnt
  );

  modport slave (
    input  enc_a, enc_b, enc_z, z_en, err_clr,
    output rot_pos, dir, sync_trg, err_cnt
  );
endinterface

// File: rtl/gb_quad_decoder.sv
// Quadrature decoder: 2-flop sync, per-line glitch filter, 4x decode
// into a wrapping position counter, index zeroing, illegal-step count.
module gb_quad_decoder #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CPR      = 0
) (
  input logic              S_AXI_ACLK,
  input logic              S_AXI_ARESET,
  gb_quad_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_W0  = 2'd0,
    ST_W1  = 2'd1,
    ST_W2  = 2'd2,
    ST_RUN = 2'd3
  } wu_t;

  localparam logic [7:0]  LP_FLIM = 8'(FILT_LEN - 1);
  localparam logic [31:0] LP_PMAX =
    (CPR == 0) ? 32'hFFFF_FFFF : 32'(CPR - 1);

  wu_t         r_wu;
  wu_t         w_wu_nxt;
  logic        w_load;
  logic        w_run;

  // bit 0 = A, bit 1 = B, bit 2 = Z
  logic [2:0]  w_raw;
  logic [2:0]  r_s1;
  logic [2:0]  r_s2;
  logic [2:0]  r_filt;
  logic [2:0]  r_prev;
  logic [7:0]  r_cnt [3];

  logic [1:0]  w_ab_cur;
  logic [1:0]  w_ab_prv;
  logic        w_same;
  logic        w_fwd;
  logic        w_rev;
  logic        w_ill;
  logic        w_zrise;

  logic [31:0] w_pos_inc;
  logic [31:0] w_pos_dec;
  logic [31:0] w_pos_nxt;
  logic        w_dir_nxt;
  logic        w_trg_nxt;
  logic [15:0] w_err_nxt;

  logic [31:0] r_rot_pos;
  logic        r_dir;
  logic        r_sync_trg;
  logic [15:0] r_err_cnt;

  function automatic logic [1:0] f_fwd(input logic [1:0] s);
    logic [1:0] n;
    unique case (s)
      2'b00: n = 2'b01;
      2'b01: n = 2'b11;
      2'b11: n = 2'b10;
      2'b10: n = 2'b00;
    endcase
    return n;
  endfunction

  assign w_raw = {bus.enc_z, bus.enc_b, bus.enc_a};

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_wu <= ST_W0;
    end else begin
      r_wu <= w_wu_nxt;
    end
  end

  // third edge after release seeds filter/prev straight from s2
  always_comb begin
    w_wu_nxt = r_wu;
    w_load   = 1'b0;
    w_run    = 1'b0;
    unique case (r_wu)
      ST_W0:  w_wu_nxt = ST_W1;
      ST_W1:  w_wu_nxt = ST_W2;
      ST_W2: begin
        w_wu_nxt = ST_RUN;
        w_load   = 1'b1;
      end
      ST_RUN: w_run = 1'b1;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_filt <= '0;
      r_prev <= '0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_load) begin
      r_filt <= r_s2;
      r_prev <= r_s2;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_prev <= r_filt;
      if (w_run) begin
        for (int i = 0; i < 3; i++) begin
          if (r_s2[i] == r_filt[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] == LP_FLIM) begin
            r_filt[i] <= r_s2[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  assign w_ab_cur = {r_filt[0], r_filt[1]};
  assign w_ab_prv = {r_prev[0], r_prev[1]};
  assign w_same   = (w_ab_cur == w_ab_prv);
  assign w_fwd    = (w_ab_cur == f_fwd(w_ab_prv));
  assign w_rev    = (w_ab_prv == f_fwd(w_ab_cur));
  assign w_ill    = ~(w_same | w_fwd | w_rev);
  assign w_zrise  = r_filt[2] & ~r_prev[2];

  assign w_pos_inc =
    (r_rot_pos == LP_PMAX) ? 32'd0 : r_rot_pos + 32'd1;
  assign w_pos_dec =
    (r_rot_pos == 32'd0) ? LP_PMAX : r_rot_pos - 32'd1;

  always_comb begin
    w_pos_nxt = r_rot_pos;
    w_dir_nxt = r_dir;
    w_err_nxt = r_err_cnt;
    w_trg_nxt = 1'b0;
    if (w_run) begin
      unique case (1'b1)
        w_same: begin
        end
        w_fwd: begin
          w_pos_nxt = w_pos_inc;
          w_dir_nxt = 1'b1;
        end
        w_rev: begin
          w_pos_nxt = w_pos_dec;
          w_dir_nxt = 1'b0;
        end
        w_ill: begin
          if (r_err_cnt != 16'hFFFF) begin
            w_err_nxt = r_err_cnt + 16'd1;
          end
        end
      endcase
      // index zeroing wins over a same-cycle step; dir still follows it
      if (w_zrise) begin
        w_trg_nxt = 1'b1;
        if (bus.z_en) begin
          w_pos_nxt = '0;
        end
      end
    end
    if (bus.err_clr) begin
      w_err_nxt = '0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_rot_pos  <= '0;
      r_dir      <= 1'b0;
      r_sync_trg <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_rot_pos  <= w_pos_nxt;
      r_dir      <= w_dir_nxt;
      r_sync_trg <= w_trg_nxt;
      r_err_cnt  <= w_err_nxt;
    end
  end

  assign bus.rot_pos  = r_rot_pos;
  assign bus.dir      = r_dir;
  assign bus.sync_trg = r_sync_trg;
  assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gb_quad_decoder.sv
// Bench for gb_quad_decoder: scoreboard of expected outputs keyed
// by the cycle they must appear, two instances (free-run, CPR=8192).
module tb_gb_quad_decoder;

  localparam int FL  = 4;
  localparam int LAT = FL + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gb_quad_decoder_if if0 ();
  gb_quad_decoder_if if1 ();

  gb_quad_decoder #(.FILT_LEN(FL), .CPR(0)) u_dut0 (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .bus         (if0)
  );

  gb_quad_decoder #(.FILT_LEN(FL), .CPR(8192)) u_dut1 (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .bus         (if1)
  );

  typedef struct {
    int          due;
    int          sel;
    int          id;
    logic [31:0] pos;
    logic        dir;
    logic        trg;
    logic [15:0] err;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_chk = 0;
  int   n_fail = 0;
  int   id = 0;

  logic [31:0] m_pos [2];
  logic        m_dir [2];
  logic [15:0] m_err [2];
  logic [1:0]  m_ab  [2];
  logic        m_z   [2];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] o_pos(input int sel);
    return (sel == 0) ? if0.rot_pos : if1.rot_pos;
  endfunction
  function automatic logic o_dir(input int sel);
    return (sel == 0) ? if0.dir : if1.dir;
  endfunction
  function automatic logic o_trg(input int sel);
    return (sel == 0) ? if0.sync_trg : if1.sync_trg;
  endfunction
  function automatic logic [15:0] o_err(input int sel);
    return (sel == 0) ? if0.err_cnt : if1.err_cnt;
  endfunction

  // forward order of {A,B}: 00,01,11,10
  function automatic logic [1:0] q_next(input logic [1:0] s,
                                         input bit fwd);
    logic [1:0] seq [4];
    int k;
    seq[0] = 2'b00; seq[1] = 2'b01;
    seq[2] = 2'b11; seq[3] = 2'b10;
    k = 0;
    for (int i = 0; i < 4; i++) if (seq[i] == s) k = i;
    return fwd ? seq[(k + 1) % 4] : seq[(k + 3) % 4];
  endfunction

  task automatic set_pins(input int sel, input logic a, input logic b,
                          input logic z);
    if (sel == 0) begin
      if0.enc_a = a; if0.enc_b = b; if0.enc_z = z;
    end else begin
      if1.enc_a = a; if1.enc_b = b; if1.enc_z = z;
    end
  endtask

  task automatic set_clr(input int sel, input logic v);
    if (sel == 0) if0.err_clr = v;
    else          if1.err_clr = v;
  endtask

  task automatic push(input int due, input int sel, input logic [31:0] p,
                      input logic d, input logic t, input logic [15:0] e);
    exp_t x;
    x.due = due; x.sel = sel; x.id = id;
    x.pos = p; x.dir = d; x.trg = t; x.err = e;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      me = q.pop_front();
      if (me.due < cyc) begin
        check_eq($sformatf("late[d%0d #%0d]", me.sel, me.id), cyc, me.due);
      end else begin
        check_eq($sformatf("pos[d%0d #%0d]", me.sel, me.id),
                 o_pos(me.sel), me.pos);
        check_eq($sformatf("dir[d%0d #%0d]", me.sel, me.id),
                 32'(o_dir(me.sel)), 32'(me.dir));
        check_eq($sformatf("trg[d%0d #%0d]", me.sel, me.id),
                 32'(o_trg(me.sel)), 32'(me.trg));
        check_eq($sformatf("err[d%0d #%0d]", me.sel, me.id),
                 32'(o_err(me.sel)), 32'(me.err));
      end
    end
  end

  // called just after a negedge; pins change now, outputs due LAT edges on
  task automatic drive(input int sel, input logic a, input logic b,
                       input logic z, input int hold, input bit clr);
    logic [31:0] p, cpr;
    logic        d, t, zen;
    logic [15:0] er;
    logic [1:0]  o, nw;
    int          c;
    id++;
    c   = cyc;
    cpr = (sel == 0) ? 32'd0 : 32'd8192;
    zen = (sel == 0) ? if0.z_en : if1.z_en;
    if (clr) begin
      set_clr(sel, 1'b1);
      m_err[sel] = '0;
    end
    push(c + LAT - 1, sel, m_pos[sel], m_dir[sel], 1'b0, m_err[sel]);
    o  = m_ab[sel];
    nw = {a, b};
    p  = m_pos[sel];
    d  = m_dir[sel];
    er = m_err[sel];
    if (nw == o) begin
    end else if (nw == q_next(o, 1'b1)) begin
      p = (cpr == 0) ? p + 32'd1 : (p + 32'd1) % cpr;
      d = 1'b1;
    end else if (nw == q_next(o, 1'b0)) begin
      p = (p != 0) ? p - 32'd1 : ((cpr == 0) ? 32'hFFFF_FFFF : cpr - 1);
      d = 1'b0;
    end else if (!clr && er != 16'hFFFF) begin
      er = er + 16'd1;
    end
    t = z & ~m_z[sel];
    if (t && zen) p = '0;
    m_pos[sel] = p; m_dir[sel] = d; m_err[sel] = er;
    m_ab[sel] = nw; m_z[sel] = z;
    push(c + LAT, sel, p, d, t, er);
    if (t) push(c + LAT + 1, sel, p, d, 1'b0, er);
    set_pins(sel, a, b, z);
    repeat (hold) @(negedge clk);
    if (clr) set_clr(sel, 1'b0);
  endtask

  task automatic step(input int sel, input bit fwd);
    logic [1:0] nw;
    nw = q_next(m_ab[sel], fwd);
    drive(sel, nw[1], nw[0], m_z[sel], 10, 1'b0);
  endtask

  task automatic glitch(input int len);
    int c;
    id++;
    c = cyc;
    for (int k = LAT - 1; k <= LAT + 4; k++)
      push(c + k, 0, m_pos[0], m_dir[0], 1'b0, m_err[0]);
    set_pins(0, ~m_ab[0][1], m_ab[0][0], m_z[0]);
    repeat (len) @(negedge clk);
    set_pins(0, m_ab[0][1], m_ab[0][0], m_z[0]);
    repeat (12) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      check_eq("drain", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_pos[s] = '0; m_dir[s] = 1'b0; m_err[s] = '0;
    end
    m_ab[0] = {if0.enc_a, if0.enc_b}; m_z[0] = if0.enc_z;
    m_ab[1] = {if1.enc_a, if1.enc_b}; m_z[1] = if1.enc_z;
  endtask

  initial begin
    int c;
    set_pins(0, 1'b0, 1'b0, 1'b0);
    set_pins(1, 1'b0, 1'b0, 1'b0);
    if0.z_en = 1'b0; if0.err_clr = 1'b0;
    if1.z_en = 1'b0; if1.err_clr = 1'b0;
    rst = 1'b1;
    #12;
    for (int s = 0; s < 2; s++) begin
      check_eq("rst_pos", o_pos(s), 32'd0);
      check_eq("rst_dir", 32'(o_dir(s)), 32'd0);
      check_eq("rst_trg", 32'(o_trg(s)), 32'd0);
      check_eq("rst_err", 32'(o_err(s)), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);

    for (int i = 0; i < 8; i++) step(0, 1'b1);
    drain();
    check_eq("fwd8_pos", o_pos(0), 32'd8);
    check_eq("fwd8_dir", 32'(o_dir(0)), 32'd1);
    for (int i = 0; i < 10; i++) step(0, 1'b0);
    drain();
    check_eq("rev10_pos", o_pos(0), 32'hFFFF_FFFE);
    check_eq("rev10_dir", 32'(o_dir(0)), 32'd0);

    glitch(3);
    drain();
    drive(0, ~m_ab[0][1], m_ab[0][0], 1'b0, 4, 1'b0);
    drive(0, ~m_ab[0][1], m_ab[0][0], 1'b0, 10, 1'b0);
    drain();

    if0.z_en = 1'b1;
    while (m_pos[0] != 32'd100) step(0, 1'b1);
    drive(0, m_ab[0][1], m_ab[0][0], 1'b1, 10, 1'b0);
    drive(0, m_ab[0][1], m_ab[0][0], 1'b0, 10, 1'b0);
    drain();
    check_eq("zen1_pos", o_pos(0), 32'd0);
    while (m_pos[0] != 32'd100) step(0, 1'b1);
    if0.z_en = 1'b0;
    drive(0, m_ab[0][1], m_ab[0][0], 1'b1, 10, 1'b0);
    drive(0, m_ab[0][1], m_ab[0][0], 1'b0, 10, 1'b0);
    drain();
    check_eq("zen0_pos", o_pos(0), 32'd100);
    if0.z_en = 1'b1;
    begin
      logic [1:0] nw;
      nw = q_next(m_ab[0], 1'b1);
      drive(0, nw[1], nw[0], 1'b1, 10, 1'b0);
    end
    drive(0, m_ab[0][1], m_ab[0][0], 1'b0, 10, 1'b0);
    drain();
    check_eq("zstep_pos", o_pos(0), 32'd0);
    if0.z_en = 1'b0;

    step(1, 1'b0);
    drain();
    check_eq("cpr_dec", o_pos(1), 32'd8191);
    step(1, 1'b1);
    drain();
    check_eq("cpr_inc", o_pos(1), 32'd0);

    while (m_ab[0] != 2'b00) step(0, 1'b1);
    drive(0, 1'b1, 1'b1, 1'b0, 10, 1'b0);
    drain();
    check_eq("ill_err", 32'(o_err(0)), 32'd1);
    force u_dut0.r_err_cnt = 16'hFFFE;
    @(negedge clk);
    release u_dut0.r_err_cnt;
    m_err[0] = 16'hFFFE;
    @(negedge clk);
    check_eq("preload", 32'(o_err(0)), 32'hFFFE);
    drive(0, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 10, 1'b0);
    drain();
    check_eq("sat_err", 32'(o_err(0)), 32'hFFFF);
    drive(0, 1'b0, 1'b0, 1'b0, 10, 1'b1);
    drain();
    check_eq("clr_err", 32'(o_err(0)), 32'd0);

    while (m_pos[0] != 32'd5) step(0, 1'b1);
    drain();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_pos", o_pos(0), 32'd0);
    check_eq("arst_dir", 32'(o_dir(0)), 32'd0);
    check_eq("arst_trg", 32'(o_trg(0)), 32'd0);
    check_eq("arst_err", 32'(o_err(0)), 32'd0);
    set_pins(0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    id++;
    c = cyc;
    for (int k = 2; k <= 14; k += 3) push(c + k, 0, 32'd0, 1'b0, 1'b0, 16'd0);
    repeat (15) @(negedge clk);
    drain();
    step(0, 1'b1);
    drain();
    check_eq("post_rst_pos", o_pos(0), 32'd1);
    check_eq("post_rst_dir", 32'(o_dir(0)), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
